// File: rtl/audio_out_pkg.sv
// Shared definitions for the audio output path.
//
// Contents:
//   amp_state_t      - amplifier power/stream state (IDLE, MUTE, RUN)
//   w_underrun_count - width of the saturating underrun counter
//   sample_period()  - clocks per sample tick for a given clock and sample rate
package audio_out_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUTE = 2'd1,
        RUN  = 2'd2
    } amp_state_t;

    localparam int w_underrun_count = 8;

    // Truncating division: the sample tick runs slightly fast when the
    // clock is not an exact multiple of the sample rate.
    function automatic int sample_period(input int clk_mhz, input int rate_hz);
        return (clk_mhz * 1000000) / rate_hz;
    endfunction

endpackage

// File: rtl/sigma_delta_dac_1st.sv
// First-order sigma-delta modulator producing a 1-bit stream.
//
// Ports:
//   clk    - system clock
//   rst_n  - asynchronous active-low reset
//   tick   - modulator update strobe
//   clear  - synchronous clear of accumulator and output (wins over tick)
//   u      - unsigned (offset-binary) modulator input
//   out    - 1-bit modulated output, changes only on tick or clear
module sigma_delta_dac_1st #(
    parameter int w_sample = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                tick,
    input  logic                clear,
    input  logic [w_sample-1:0] u,
    output logic                out
);

    logic [w_sample-1:0] acc;
    logic [w_sample:0]   sum;

    // The carry out of the accumulator is the output bit; its density
    // equals u / 2^w_sample.
    assign sum = {1'b0, acc} + {1'b0, u};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            out <= 1'b0;
        end else if (clear) begin
            acc <= '0;
            out <= 1'b0;
        end else if (tick) begin
            acc <= sum[w_sample-1:0];
            out <= sum[w_sample];
        end
    end

endmodule

// File: rtl/pmod_amp2_sigma_delta_out.sv
// PCM-to-sigma-delta output stage for the Digilent PMOD AMP2.
//
// Parameters:
//   clk_mhz, sample_rate_hz - set the sample tick period P
//   w_sample                - signed PCM sample width
//   mod_div                 - clocks per modulator tick
//   mute_ticks              - sample ticks spent in MUTE before RUN
//   high_gain               - static value for the GAIN pin
//
// Ports:
//   clk, rst_n              - clock, asynchronous active-low reset
//   enable                  - amplifier enable request
//   sample, sample_valid    - PCM input (valid/ready handshake)
//   sample_ready            - one-entry buffer can take a sample this cycle
//   ain                     - 1-bit stream to AIN
//   shutdown_n, gain        - amplifier control pins
//   underrun                - pulse on a RUN sample tick with nothing buffered
//   underrun_count          - saturating count of underrun pulses
module pmod_amp2_sigma_delta_out
    import audio_out_pkg::*;
#(
    parameter int clk_mhz        = 100,
    parameter int sample_rate_hz = 48000,
    parameter int w_sample       = 16,
    parameter int mod_div        = 4,
    parameter int mute_ticks     = 1024,
    parameter int high_gain      = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        enable,
    input  logic [w_sample-1:0]         sample,
    input  logic                        sample_valid,
    output logic                        sample_ready,
    output logic                        ain,
    output logic                        shutdown_n,
    output logic                        gain,
    output logic                        underrun,
    output logic [w_underrun_count-1:0] underrun_count
);

    localparam int period   = sample_period(clk_mhz, sample_rate_hz);
    localparam int period_w = (period > 1) ? $clog2(period) : 1;
    localparam int mod_w    = (mod_div > 1) ? $clog2(mod_div) : 1;
    localparam int mute_w   = (mute_ticks > 1) ? $clog2(mute_ticks) : 1;

    logic [period_w-1:0] smp_cnt;
    logic [mod_w-1:0]    mod_cnt;
    logic                sample_tick;
    logic                mod_tick;

    amp_state_t          state;
    amp_state_t          state_next;
    logic [mute_w-1:0]   mute_cnt;
    logic                run;
    logic                clear;

    logic                buf_full;
    logic [w_sample-1:0] buf_data;
    logic [w_sample-1:0] hold;
    logic                accept;
    logic                load;
    logic [w_sample-1:0] u;

    assign sample_tick = (smp_cnt == period_w'(period - 1));
    assign mod_tick    = (mod_cnt == mod_w'(mod_div - 1));

    // Both tick counters run freely in every state so the sample and
    // modulator timing is independent of enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            smp_cnt <= '0;
            mod_cnt <= '0;
        end else begin
            smp_cnt <= sample_tick ? '0 : smp_cnt + 1'b1;
            mod_cnt <= mod_tick ? '0 : mod_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Dropping enable returns to IDLE from anywhere; MUTE leaves on its
    // mute_ticks-th sample tick.
    always_comb begin
        state_next = state;
        if (!enable) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    state_next = MUTE;
                MUTE:    if (sample_tick && (mute_cnt == mute_w'(mute_ticks - 1)))
                             state_next = RUN;
                RUN:     state_next = RUN;
                default: state_next = IDLE;
            endcase
        end
    end

    // Counts sample ticks seen in MUTE; parked at zero elsewhere.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mute_cnt <= '0;
        end else if (state != MUTE) begin
            mute_cnt <= '0;
        end else if (sample_tick) begin
            mute_cnt <= mute_cnt + 1'b1;
        end
    end

    assign run          = (state == RUN);
    assign clear        = (state_next == IDLE);
    assign sample_ready = run && (!buf_full || sample_tick);
    assign accept       = sample_valid && sample_ready;
    assign load         = run && sample_tick && buf_full;
    assign underrun     = run && sample_tick && !buf_full;

    // The buffer may be drained into hold and refilled on the same tick.
    // Clearing on the edge into IDLE discards anything still buffered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_full <= 1'b0;
            buf_data <= '0;
            hold     <= '0;
        end else if (clear) begin
            buf_full <= 1'b0;
            buf_data <= '0;
            hold     <= '0;
        end else begin
            if (load) begin
                hold <= buf_data;
            end
            if (accept) begin
                buf_data <= sample;
                buf_full <= 1'b1;
            end else if (load) begin
                buf_full <= 1'b0;
            end
        end
    end

    // Survives IDLE so software can read the history after a stop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underrun_count <= '0;
        end else if (underrun && (underrun_count != '1)) begin
            underrun_count <= underrun_count + 1'b1;
        end
    end

    // Flipping the MSB maps signed PCM onto offset binary; outside RUN the
    // modulator idles at midscale, which is a 50% duty (silent) stream.
    always_comb begin
        u = {1'b1, {(w_sample-1){1'b0}}};
        if (run) begin
            u = {~hold[w_sample-1], hold[w_sample-2:0]};
        end
    end

    sigma_delta_dac_1st #(
        .w_sample (w_sample)
    ) u_dac (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (mod_tick),
        .clear (clear),
        .u     (u),
        .out   (ain)
    );

    assign shutdown_n = (state != IDLE);
    assign gain       = (high_gain != 0);

endmodule

// File: tb/tb_pmod_amp2_sigma_delta_out.sv
// Self-checking bench for pmod_amp2_sigma_delta_out (P=10, mod_div=1,
// mute_ticks=4). Accepted samples are queued as they are handed over and
// popped when a RUN sample tick should move them into the modulator; a
// behavioural model turns the popped values into the expected ain stream.
module tb_pmod_amp2_sigma_delta_out;

    localparam int CLK_MHZ    = 1;
    localparam int RATE_HZ    = 100000;
    localparam int P          = 10;
    localparam int MOD_DIV    = 1;
    localparam int MUTE_TICKS = 4;
    localparam int W          = 16;
    localparam int HIGH_GAIN  = 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         enable = 1'b0;
    logic [W-1:0] sample = '0;
    logic         sample_valid = 1'b0;
    logic         sample_ready;
    logic         ain;
    logic         shutdown_n;
    logic         gain;
    logic         underrun;
    logic [7:0]   underrun_count;

    int tests_run = 0;
    int tests_failed = 0;
    int stalls = 0;

    // Reference model state, valid between rising edges.
    int m_state = 0;
    int m_scnt = 0;
    int m_mcnt = 0;
    int m_mute_seen = 0;
    int m_hold = 0;
    int m_acc = 0;
    bit m_ain = 1'b0;
    int m_ucount = 0;
    int exp_q[$];

    pmod_amp2_sigma_delta_out #(
        .clk_mhz        (CLK_MHZ),
        .sample_rate_hz (RATE_HZ),
        .w_sample       (W),
        .mod_div        (MOD_DIV),
        .mute_ticks     (MUTE_TICKS),
        .high_gain      (HIGH_GAIN)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .sample         (sample),
        .sample_valid   (sample_valid),
        .sample_ready   (sample_ready),
        .ain            (ain),
        .shutdown_n     (shutdown_n),
        .gain           (gain),
        .underrun       (underrun),
        .underrun_count (underrun_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        tests_run++;
        if (observed != expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit en, input bit valid, input int value);
        enable       = en;
        sample_valid = valid;
        sample       = W'(value);
    endtask

    // Holds sample_valid until the block takes the value.
    task automatic sendSample(input int value, output bit ok);
        applyStimulus(1'b1, 1'b1, value);
        ok = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (sample_ready) ok = 1'b1;
            else stalls++;
            @(posedge clk);
            #1;
            if (ok) break;
        end
    endtask

    task automatic countOnes(input int n, output int ones);
        ones = 0;
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            ones += int'(ain);
        end
    endtask

    // Cycles from enable until sample_ready rises (RUN reached).
    task automatic waitForRun(output int n);
        n = 0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) checkOutput("shutdown_n_next_cycle", int'(shutdown_n), 1);
            if (sample_ready) break;
        end
    endtask

    // Compare on the falling edge, then step the model with the inputs the
    // DUT will see at the coming rising edge.
    always @(negedge clk) begin
        bit tick;
        bit mtick;
        bit exp_ready;
        bit exp_under;
        int ns;
        int u;
        int sum;
        if (!rst_n) begin
            checkOutput("reset_ain", int'(ain), 0);
            checkOutput("reset_shutdown_n", int'(shutdown_n), 0);
            checkOutput("reset_sample_ready", int'(sample_ready), 0);
            checkOutput("reset_underrun", int'(underrun), 0);
            checkOutput("reset_underrun_count", int'(underrun_count), 0);
            checkOutput("reset_gain", int'(gain), HIGH_GAIN);
            m_state = 0; m_scnt = 0; m_mcnt = 0; m_mute_seen = 0;
            m_hold = 0; m_acc = 0; m_ain = 1'b0; m_ucount = 0;
            exp_q.delete();
        end else begin
            tick      = (m_scnt == P - 1);
            mtick     = (m_mcnt == MOD_DIV - 1);
            exp_ready = (m_state == 2) && (exp_q.size() == 0 || tick);
            exp_under = (m_state == 2) && tick && (exp_q.size() == 0);
            checkOutput("ain", int'(ain), int'(m_ain));
            checkOutput("shutdown_n", int'(shutdown_n), (m_state != 0) ? 1 : 0);
            checkOutput("sample_ready", int'(sample_ready), int'(exp_ready));
            checkOutput("underrun", int'(underrun), int'(exp_under));
            checkOutput("underrun_count", int'(underrun_count), m_ucount);
            checkOutput("gain", int'(gain), HIGH_GAIN);

            if (!enable) ns = 0;
            else if (m_state == 0) ns = 1;
            else if (m_state == 1) ns = (tick && m_mute_seen + 1 == MUTE_TICKS) ? 2 : 1;
            else ns = 2;

            u = (m_state == 2) ? m_hold + 32768 : 32768;
            if (mtick) begin
                sum   = m_acc + u;
                m_ain = (sum >= 65536);
                m_acc = sum % 65536;
            end
            if (exp_under && m_ucount < 255) m_ucount++;
            if (m_state == 2 && tick && exp_q.size() > 0) m_hold = exp_q.pop_front();
            if (sample_valid && exp_ready) exp_q.push_back(int'($signed(sample)));
            if (m_state == 1 && tick) m_mute_seen++;
            if (ns != 1) m_mute_seen = 0;
            if (ns == 0) begin
                exp_q.delete();
                m_hold = 0;
                m_acc  = 0;
                m_ain  = 1'b0;
            end
            m_scnt  = (m_scnt == P - 1) ? 0 : m_scnt + 1;
            m_mcnt  = (m_mcnt == MOD_DIV - 1) ? 0 : m_mcnt + 1;
            m_state = ns;
        end
    end

    initial begin
        int n;
        int ones;
        int pulses;
        bit ok;
        int accepted;

        // Reset held while enable and sample_valid are already asserted.
        applyStimulus(1'b1, 1'b1, 1234);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("reset_hold_ain", int'(ain), 0);
        checkOutput("reset_hold_ready", int'(sample_ready), 0);
        rst_n = 1'b1;
        waitForRun(n);
        checkOutput("mute_cycles_after_reset", n, 40);

        // Zero input: midscale stream alternates, exactly half ones.
        applyStimulus(1'b1, 1'b1, 0);
        repeat (100) @(posedge clk);
        #1;
        countOnes(64, ones);
        checkOutput("zero_ones_in_64", ones, 32);

        // Positive full scale: at most one zero per wrap of the accumulator.
        applyStimulus(1'b1, 1'b1, 32767);
        repeat (60) @(posedge clk);
        #1;
        countOnes(64, ones);
        checkOutput("max_pos_ones_ge_63", (ones >= 63) ? 1 : 0, 1);

        // Negative full scale: u = 0, stream stays low.
        applyStimulus(1'b1, 1'b1, -32768);
        repeat (60) @(posedge clk);
        #1;
        countOnes(64, ones);
        checkOutput("max_neg_ones", ones, 0);

        // Back-to-back samples with valid held: order and backpressure.
        stalls = 0;
        accepted = 0;
        for (int i = 0; i < 8; i++) begin
            sendSample(i * 7000 - 25000, ok);
            if (ok) accepted++;
        end
        checkOutput("sequence_accepted", accepted, 8);
        checkOutput("backpressure_seen", (stalls > 0) ? 1 : 0, 1);

        // Starve the buffer for 300 sample ticks.
        applyStimulus(1'b1, 1'b0, 0);
        repeat (20) @(posedge clk);
        #1;
        pulses = 0;
        for (int c = 0; c < 300 * P; c++) begin
            @(posedge clk);
            #1;
            pulses += int'(underrun);
        end
        checkOutput("underrun_pulses", pulses, 300);
        checkOutput("underrun_count_saturated", int'(underrun_count), 255);

        // Drop enable with a sample sitting in the buffer.
        sendSample(5000, ok);
        checkOutput("fill_before_disable", int'(ok), 1);
        applyStimulus(1'b0, 1'b0, 0);
        @(posedge clk);
        #1;
        checkOutput("disable_shutdown_n", int'(shutdown_n), 0);
        checkOutput("disable_ain", int'(ain), 0);
        checkOutput("disable_ready", int'(sample_ready), 0);
        checkOutput("disable_underrun_count", int'(underrun_count), 255);
        repeat (7) @(posedge clk);
        #1;

        // Re-enable: another full MUTE period before RUN.
        applyStimulus(1'b1, 1'b0, 0);
        waitForRun(n);
        checkOutput("mute_cycles_reenable", (n >= 32 && n <= 41) ? 1 : 0, 1);
        repeat (2 * P) @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
